// File: rtl/traffic_light_pkg.sv
// Shared constants and helpers for the traffic-light phase timer:
// phase one-hot encodings, display range, countdown width and BCD split.
package traffic_light_pkg;

  // Width of the remaining-seconds countdown (holds 0..99).
  localparam int REMAIN_W    = 7;
  // Largest value the road-side display can show.
  localparam int MAX_DISPLAY = 99;

  typedef logic [2:0]          phase_t;
  typedef logic [REMAIN_W-1:0] sec_t;

  // Phase vector ordering is {green, yellow, red}.
  localparam phase_t PH_GREEN  = 3'b100;
  localparam phase_t PH_YELLOW = 3'b010;
  localparam phase_t PH_RED    = 3'b001;

  // What the timer does in the current cycle, decoded from the phase inputs.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,  // phase inputs not one-hot: freeze everything
    ACT_LOAD  = 2'd1,  // new one-hot phase: load its duration
    ACT_COUNT = 2'd2,  // same phase, seconds left: run the prescaler
    ACT_DONE  = 2'd3   // same phase, nothing left: idle, no pulses
  } timer_act_e;

  // True when exactly one phase bit is set.
  function automatic logic is_one_hot(input phase_t ph);
    return (ph != 3'b000) && ((ph & (ph - 3'b001)) == 3'b000);
  endfunction

  // BCD tens digit for a value in 0..MAX_DISPLAY.
  function automatic logic [3:0] bcd_tens(input sec_t s);
    sec_t q;
    q = s / sec_t'(10);
    return q[3:0];
  endfunction

  // BCD ones digit for a value in 0..MAX_DISPLAY.
  function automatic logic [3:0] bcd_ones(input sec_t s);
    sec_t r;
    r = s % sec_t'(10);
    return r[3:0];
  endfunction

endpackage

// File: rtl/traffic_light_timer_if.sv
// Signal bundle between the light FSM (master) and the phase timer (slave).
//
// Protocol: the FSM holds exactly one of state_green/state_yellow/state_red
// high for as long as it sits in that phase. A change to a different one-hot
// value starts a new phase one cycle later. The timer answers with a single
// cycle *_end pulse for the phase that elapsed; the FSM samples the pulse at
// the end of that cycle and moves on. There is no back-pressure: a pulse is
// never repeated, and an abandoned phase never pulses. remain_* and
// phase_err are plain registered status values, valid every cycle.
interface traffic_light_timer_if;
  import traffic_light_pkg::*;

  logic                state_green;
  logic                state_yellow;
  logic                state_red;
  logic                green_end;
  logic                yellow_end;
  logic                red_end;
  logic [REMAIN_W-1:0] remain_sec;
  logic [3:0]          remain_tens;
  logic [3:0]          remain_ones;
  logic                phase_err;

  modport master (
    output state_green, state_yellow, state_red,
    input  green_end, yellow_end, red_end,
    input  remain_sec, remain_tens, remain_ones, phase_err
  );

  modport slave (
    input  state_green, state_yellow, state_red,
    output green_end, yellow_end, red_end,
    output remain_sec, remain_tens, remain_ones, phase_err
  );

endinterface

// File: rtl/traffic_light_timer_tick_gen.sv
// 1 s prescaler: counts 0..TICK_DIV-1 while enabled and flags the last count.
// clr restarts the second from zero; when en is low the count freezes.
module tl_tick_gen #(
  parameter int TICK_DIV = 50_000_000  // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int             CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A frozen prescaler parked on LAST must not produce a tick.
  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/traffic_light_timer.sv
// Phase timer for the traffic-light controller. Detects entry into a new
// one-hot phase, loads that phase's duration, counts it down once per
// prescaler tick and emits a single end pulse when it reaches zero.
module traffic_light_timer
  import traffic_light_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,  // clk cycles per second, >= 2
  parameter int GREEN_SEC  = 30,          // 1..99
  parameter int YELLOW_SEC = 3,           // 1..99
  parameter int RED_SEC    = 2            // 1..99
) (
  input  logic                  clk,
  input  logic                  rst,
  traffic_light_timer_if.slave  tl
);

  localparam sec_t GREEN_D  = sec_t'(GREEN_SEC);
  localparam sec_t YELLOW_D = sec_t'(YELLOW_SEC);
  localparam sec_t RED_D    = sec_t'(RED_SEC);

  phase_t     ph;
  phase_t     ph_q;
  phase_t     ph_d;
  sec_t       sec_cnt_q;
  sec_t       sec_cnt_d;
  phase_t     end_q;      // {green_end, yellow_end, red_end}
  phase_t     end_d;
  logic       err_q;
  logic       err_d;
  logic       ph_valid;
  logic       ph_new;
  logic       count_en;
  logic       tick;
  timer_act_e act;

  // Duration in seconds for a one-hot phase.
  function automatic sec_t phase_duration(input phase_t p);
    sec_t d;
    case (p)
      PH_GREEN:  d = GREEN_D;
      PH_YELLOW: d = YELLOW_D;
      PH_RED:    d = RED_D;
      default:   d = '0;
    endcase
    return d;
  endfunction

  assign ph       = {tl.state_green, tl.state_yellow, tl.state_red};
  assign ph_valid = is_one_hot(ph);
  assign ph_new   = ph_valid && (ph != ph_q);
  assign count_en = ph_valid && !ph_new && (sec_cnt_q != '0);

  tl_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (ph_new),
    .en   (count_en),
    .tick (tick)
  );

  // Classify the cycle; load has priority over a coincident final tick.
  always_comb begin
    act = ACT_DONE;
    if (!ph_valid) begin
      act = ACT_HOLD;
    end else if (ph_new) begin
      act = ACT_LOAD;
    end else if (count_en) begin
      act = ACT_COUNT;
    end
  end

  // Next countdown value, end pulses and error flag.
  always_comb begin
    ph_d      = ph;
    sec_cnt_d = sec_cnt_q;
    end_d     = '0;
    err_d     = !ph_valid;
    case (act)
      ACT_LOAD: begin
        sec_cnt_d = phase_duration(ph);
      end
      ACT_COUNT: begin
        if (tick) begin
          sec_cnt_d = sec_cnt_q - sec_t'(1);
          // The tick that empties the counter ends the current phase.
          if (sec_cnt_q == sec_t'(1)) begin
            end_d = ph;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Phase copy, countdown, pulse and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q      <= '0;
      sec_cnt_q <= '0;
      end_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      ph_q      <= ph_d;
      sec_cnt_q <= sec_cnt_d;
      end_q     <= end_d;
      err_q     <= err_d;
    end
  end

  assign tl.green_end   = end_q[2];
  assign tl.yellow_end  = end_q[1];
  assign tl.red_end     = end_q[0];
  assign tl.remain_sec  = sec_cnt_q;
  assign tl.remain_tens = bcd_tens(sec_cnt_q);
  assign tl.remain_ones = bcd_ones(sec_cnt_q);
  assign tl.phase_err   = err_q;

endmodule

// File: tb/tb_traffic_light_timer.sv
// Bench for traffic_light_timer: directed scenarios plus a randomized run,
// all compared against an elapsed-time reference model.
module tb_traffic_light_timer;
  import traffic_light_pkg::*;

  localparam int T  = 4;
  localparam int GS = 3;
  localparam int YS = 2;
  localparam int RS = 1;

  logic clk = 1'b0;
  logic rst;

  traffic_light_timer_if tl_if ();

  traffic_light_timer #(
    .TICK_DIV   (T),
    .GREEN_SEC  (GS),
    .YELLOW_SEC (YS),
    .RED_SEC    (RS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tl  (tl_if)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  // A phase of D seconds needs D*T counting cycles after its load; remaining
  // seconds are D minus whole seconds elapsed, and the end pulse follows the
  // cycle in which the elapsed count reaches D*T.
  logic [2:0] m_phq;
  logic [2:0] m_pulse;
  logic       m_err;
  int         m_d;
  int         m_el;

  function automatic bit one_hot3(input logic [2:0] p);
    return $countones(p) == 1;
  endfunction

  function automatic int dur_of(input logic [2:0] p);
    if (p == 3'b100) return GS;
    if (p == 3'b010) return YS;
    if (p == 3'b001) return RS;
    return 0;
  endfunction

  task automatic model_reset();
    m_phq   = 3'b000;
    m_pulse = 3'b000;
    m_err   = 1'b0;
    m_d     = 0;
    m_el    = 0;
  endtask

  task automatic model_edge(input logic [2:0] p);
    m_err   = !one_hot3(p);
    m_pulse = 3'b000;
    if (one_hot3(p) && p != m_phq) begin
      m_d  = dur_of(p);
      m_el = 0;
    end else if (one_hot3(p) && m_el < m_d * T) begin
      m_el++;
      if (m_el == m_d * T) m_pulse = p;
    end
    m_phq = p;
  endtask

  function automatic logic [18:0] exp_vec();
    int rem;
    rem = m_d - m_el / T;
    return {m_pulse, m_err, 7'(rem), 4'(rem / 10), 4'(rem % 10)};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {tl_if.green_end, tl_if.yellow_end, tl_if.red_end, tl_if.phase_err,
            tl_if.remain_sec, tl_if.remain_tens, tl_if.remain_ones};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_ph(input logic [2:0] p);
    {tl_if.state_green, tl_if.state_yellow, tl_if.state_red} = p;
  endtask

  // Called at a negedge: drive ph for one cycle, advance the model at the
  // edge, return at the next negedge with outputs settled.
  task automatic step(input logic [2:0] p);
    set_ph(p);
    @(posedge clk);
    model_edge(p);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_ph(3'b000);
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs_vec() !== 19'h0) $display("FAIL reset_state: got %h want %h", obs_vec(), 19'h0);
    else n_pass++;
  endtask

  task automatic test_reset_then_red();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(3'b001);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL red_model i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      if (tl_if.red_end !== (i == 4)) $display("FAIL red_end_cycle i=%0d: got %b want %b", i, tl_if.red_end, (i == 4));
      else n_pass++;
      if (i == 0 || i >= 4) begin
        n_checks++;
        if (tl_if.remain_sec !== ((i == 0) ? 7'd1 : 7'd0))
          $display("FAIL red_remain i=%0d: got %0d want %0d", i, tl_if.remain_sec, (i == 0) ? 1 : 0);
        else n_pass++;
      end
    end
  endtask

  task automatic test_green();
    logic [6:0] want;
    for (int i = 0; i < 16; i++) begin
      step(3'b100);
      want = (i < 4) ? 7'd3 : (i < 8) ? 7'd2 : (i < 12) ? 7'd1 : 7'd0;
      n_checks++;
      if (tl_if.remain_sec !== want) $display("FAIL green_remain i=%0d: got %0d want %0d", i, tl_if.remain_sec, want);
      else n_pass++;
      n_checks++;
      if (tl_if.green_end !== (i == 12)) $display("FAIL green_end_cycle i=%0d: got %b want %b", i, tl_if.green_end, (i == 12));
      else n_pass++;
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL green_model i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      else n_pass++;
      if (i == 0) begin
        n_checks++;
        if ({tl_if.remain_tens, tl_if.remain_ones} !== 8'h03)
          $display("FAIL green_bcd: got %h want %h", {tl_if.remain_tens, tl_if.remain_ones}, 8'h03);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stuck();
    int pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(3'b010);
      if (tl_if.yellow_end === 1'b1) pulses++;
      n_checks++;
      if (tl_if.yellow_end !== (i == 8)) $display("FAIL stuck_pulse i=%0d: got %b want %b", i, tl_if.yellow_end, (i == 8));
      else n_pass++;
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL stuck_model i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (pulses != 1 || tl_if.remain_sec !== 7'd0)
      $display("FAIL stuck_total: got pulses=%0d remain=%0d want pulses=1 remain=0", pulses, tl_if.remain_sec);
    else n_pass++;
  endtask

  task automatic test_mid_change();
    for (int i = 0; i < 14; i++) begin
      step((i < 6) ? 3'b100 : 3'b001);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL mid_model i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      if (tl_if.green_end !== 1'b0) $display("FAIL mid_no_green i=%0d: got %b want 0", i, tl_if.green_end);
      else n_pass++;
      if (i >= 6) begin
        n_checks++;
        if (tl_if.red_end !== (i == 10)) $display("FAIL mid_red_end i=%0d: got %b want %b", i, tl_if.red_end, (i == 10));
        else n_pass++;
      end
      if (i == 6) begin
        n_checks++;
        if (tl_if.remain_sec !== 7'd1) $display("FAIL mid_reload: got %0d want 1", tl_if.remain_sec);
        else n_pass++;
      end
    end
  endtask

  task automatic test_invalid();
    logic [2:0] p;
    for (int i = 0; i < 20; i++) begin
      p = (i < 6) ? 3'b100 : (i < 14) ? 3'b110 : 3'b001;
      step(p);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL inv_model i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      else n_pass++;
      if (i >= 6 && i < 14) begin
        n_checks++;
        if ({tl_if.phase_err, tl_if.remain_sec, tl_if.green_end, tl_if.yellow_end, tl_if.red_end} !== {1'b1, 7'd2, 3'b000})
          $display("FAIL inv_frozen i=%0d: got err=%b remain=%0d want err=1 remain=2 no pulse",
                   i, tl_if.phase_err, tl_if.remain_sec);
        else n_pass++;
      end
      if (i == 14) begin
        n_checks++;
        if ({tl_if.phase_err, tl_if.remain_sec} !== {1'b0, 7'd1})
          $display("FAIL inv_recover: got err=%b remain=%0d want err=0 remain=1", tl_if.phase_err, tl_if.remain_sec);
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(3'b100);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs_vec() !== 19'h0) $display("FAIL async_reset: got %h want %h", obs_vec(), 19'h0);
    else n_pass++;
    model_reset();
    set_ph(3'b000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step((i < 10) ? 3'b000 : 3'b100);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL post_reset_model i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      if ({tl_if.green_end, tl_if.yellow_end, tl_if.red_end} !== 3'b000)
        $display("FAIL post_reset_pulse i=%0d: got %b want 000", i, {tl_if.green_end, tl_if.yellow_end, tl_if.red_end});
      else n_pass++;
    end
    n_checks++;
    if (tl_if.remain_sec !== 7'd3) $display("FAIL post_reset_load: got %0d want 3", tl_if.remain_sec);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0] p;
    int run;
    int cyc = 0;
    while (cyc < 900) begin
      case ($urandom_range(0, 9))
        0, 1, 2: p = 3'b100;
        3, 4:    p = 3'b010;
        5, 6:    p = 3'b001;
        default: p = 3'($urandom_range(0, 7));
      endcase
      run = $urandom_range(1, 20);
      for (int k = 0; k < run; k++) begin
        step(p);
        cyc++;
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL random cyc=%0d ph=%b: got %h want %h", cyc, p, obs_vec(), exp_vec());
        else n_pass++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_reset_then_red();
    test_green();
    test_stuck();
    test_mid_change();
    test_invalid();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
